// File: rtl/cache_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one memory port; round-robin on ties, one grant at a time.
// Grant one cycle after a request is seen in IDLE; resp pulses combinationally with mem_resp; a DONE gap separates grants.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [31:0]       conflict_count
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_grant_d_q;  // 1 = dcache held the most recent grant
  logic [31:0] conflict_q;
  logic        i_req, d_req;

  assign i_req             = icache_pmem_read;
  assign d_req             = dcache_pmem_read | dcache_pmem_write;
  assign icache_pmem_rdata = mem_rdata;
  assign dcache_pmem_rdata = mem_rdata;
  assign conflict_count    = conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == GRANT_I)
        last_grant_d_q <= 1'b0;
      else if (state_q == IDLE && state_d == GRANT_D)
        last_grant_d_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_q <= 32'd0;
    else if (state_q == IDLE && i_req && d_req && conflict_q != 32'hFFFF_FFFF)
      conflict_q <= conflict_q + 32'd1;
  end

  always_comb begin
    state_d          = state_q;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_address      = '0;
    mem_wdata        = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req)
          state_d = last_grant_d_q ? GRANT_I : GRANT_D;
        else if (i_req)
          state_d = GRANT_I;
        else if (d_req)
          state_d = GRANT_D;
      end
      GRANT_I: begin
        mem_read    = 1'b1;
        mem_address = icache_pmem_address;
        if (mem_resp) begin
          icache_pmem_resp = 1'b1;
          state_d          = DONE;
        end
      end
      GRANT_D: begin
        // write takes precedence when both dcache strobes are up
        mem_write   = dcache_pmem_write;
        mem_read    = ~dcache_pmem_write;
        mem_address = dcache_pmem_address;
        mem_wdata   = dcache_pmem_wdata;
        if (mem_resp) begin
          dcache_pmem_resp = 1'b1;
          state_d          = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-requester fills/writebacks, ties, alternation, reset abort, counter saturation.
module tb_cache_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef logic [LINE_W-1:0] w_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;
  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic [31:0]       conflict_count;

  int n_checks = 0;
  int n_fail   = 0;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_address         (mem_address),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_resp            (mem_resp),
    .conflict_count      (conflict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input w_t obs, input w_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the grant, checks the memory-side request, answers it and checks the resp and DONE gap.
  // Called at a negedge in IDLE with the request already driven; returns at the negedge of the following IDLE.
  task automatic serve(input string tag, input bit is_d, input bit is_wr,
                       input logic [ADDR_W-1:0] addr, input w_t wdat, input w_t rdat, input bit drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(mem_read || mem_write) && n < 20);
    check({tag, "_latency"}, w_t'(n), w_t'(1));
    check({tag, "_mem_read"}, w_t'(mem_read), w_t'(!is_wr));
    check({tag, "_mem_write"}, w_t'(mem_write), w_t'(is_wr));
    check({tag, "_mem_address"}, w_t'(mem_address), w_t'(addr));
    check({tag, "_mem_wdata"}, mem_wdata, is_d ? wdat : w_t'(0));
    repeat (4) begin
      @(negedge clk);
      #1;
      check({tag, "_no_early_resp"}, w_t'({icache_pmem_resp, dcache_pmem_resp}), w_t'(0));
    end
    mem_rdata = rdat;
    mem_resp  = 1'b1;
    #1;
    check({tag, "_icache_resp"}, w_t'(icache_pmem_resp), w_t'(!is_d));
    check({tag, "_dcache_resp"}, w_t'(dcache_pmem_resp), w_t'(is_d));
    check({tag, "_rdata"}, is_d ? dcache_pmem_rdata : icache_pmem_rdata, rdat);
    @(negedge clk);
    #1;
    // mem_resp is still high here: DONE must ignore it
    check({tag, "_done_req"}, w_t'({mem_read, mem_write}), w_t'(0));
    check({tag, "_done_addr"}, w_t'(mem_address), w_t'(0));
    check({tag, "_done_resp"}, w_t'({icache_pmem_resp, dcache_pmem_resp}), w_t'(0));
    mem_resp = 1'b0;
    if (drop) begin
      if (is_d) begin
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
      end else begin
        icache_pmem_read = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    w_t rd_val;
    rst                 = 1'b1;
    icache_pmem_read    = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;
    mem_rdata           = {8{32'h1234_5678}};
    mem_resp            = 1'b0;

    @(negedge clk);
    #1;
    check("rst_mem_req", w_t'({mem_read, mem_write}), w_t'(0));
    check("rst_mem_addr", w_t'(mem_address), w_t'(0));
    check("rst_mem_wdata", mem_wdata, w_t'(0));
    check("rst_resp", w_t'({icache_pmem_resp, dcache_pmem_resp}), w_t'(0));
    check("rst_conflict", w_t'(conflict_count), w_t'(0));
    check("rst_i_rdata", icache_pmem_rdata, {8{32'h1234_5678}});
    check("rst_d_rdata", dcache_pmem_rdata, {8{32'h1234_5678}});
    @(negedge clk);
    rst = 1'b0;

    // icache fill alone
    @(negedge clk);
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_0040;
    #1;
    check("t1_idle_no_req", w_t'(mem_read), w_t'(0));
    serve("t1", 1'b0, 1'b0, 32'h0000_0040, w_t'(0), {32{8'hA5}}, 1'b1);

    // dcache writeback alone
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 32'h1000_0080;
    dcache_pmem_wdata   = {32{8'h3C}};
    serve("t2", 1'b1, 1'b1, 32'h1000_0080, {32{8'h3C}}, {32{8'h11}}, 1'b1);
    check("t2_conflict", w_t'(conflict_count), w_t'(0));

    // both from reset: dcache first
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_0200;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 32'h0000_0300;
    dcache_pmem_wdata   = {32{8'h5A}};
    serve("t3d", 1'b1, 1'b0, 32'h0000_0300, {32{8'h5A}}, {32{8'h22}}, 1'b1);
    serve("t3i", 1'b0, 1'b0, 32'h0000_0200, w_t'(0), {32{8'h33}}, 1'b1);
    check("t3_conflict", w_t'(conflict_count), w_t'(1));

    // both held: D, I, D, I
    icache_pmem_read = 1'b1;
    dcache_pmem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        serve("t4d", 1'b1, 1'b0, 32'h0000_0300, {32{8'h5A}}, {32{8'h44}}, 1'b0);
      else
        serve("t4i", 1'b0, 1'b0, 32'h0000_0200, w_t'(0), {32{8'h55}}, 1'b0);
    end
    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;
    @(negedge clk);
    #1;
    check("t4_conflict", w_t'(conflict_count), w_t'(5));
    check("t4_idle_req", w_t'({mem_read, mem_write}), w_t'(0));

    // reset mid-grant abandons the writeback
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 32'h1000_0080;
    dcache_pmem_wdata   = {32{8'hC3}};
    @(negedge clk);
    #1;
    check("t5_granted", w_t'(mem_write), w_t'(1));
    #2;
    rst      = 1'b1;
    mem_resp = 1'b1;
    #1;
    check("t5_rst_req", w_t'({mem_read, mem_write}), w_t'(0));
    check("t5_rst_addr", w_t'(mem_address), w_t'(0));
    check("t5_rst_wdata", mem_wdata, w_t'(0));
    check("t5_rst_dresp", w_t'(dcache_pmem_resp), w_t'(0));
    check("t5_rst_conflict", w_t'(conflict_count), w_t'(0));
    @(negedge clk);
    rst      = 1'b0;
    mem_resp = 1'b0;
    serve("t5", 1'b1, 1'b1, 32'h1000_0080, {32{8'hC3}}, {32{8'h66}}, 1'b1);

    // counter saturation: last grant was dcache, so ties go I, D, I
    force dut.conflict_q = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_q;
    icache_pmem_read    = 1'b1;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = 32'h0000_0300;
    dcache_pmem_wdata   = {32{8'h5A}};
    serve("t6i", 1'b0, 1'b0, 32'h0000_0200, w_t'(0), {32{8'h77}}, 1'b0);
    check("t6_conflict_first", w_t'(conflict_count), w_t'(32'hFFFF_FFFF));
    serve("t6d", 1'b1, 1'b0, 32'h0000_0300, {32{8'h5A}}, {32{8'h88}}, 1'b0);
    serve("t6i2", 1'b0, 1'b0, 32'h0000_0200, w_t'(0), {32{8'h99}}, 1'b1);
    dcache_pmem_read = 1'b0;
    @(negedge clk);
    #1;
    check("t6_conflict_sat", w_t'(conflict_count), w_t'(32'hFFFF_FFFF));

    // stray mem_resp in IDLE, rdata passthrough
    rd_val    = {8{32'hDEAD_BEEF}};
    mem_rdata = rd_val;
    mem_resp  = 1'b1;
    #1;
    check("idle_stray_resp", w_t'({icache_pmem_resp, dcache_pmem_resp}), w_t'(0));
    check("idle_i_rdata", icache_pmem_rdata, rd_val);
    check("idle_d_rdata", dcache_pmem_rdata, rd_val);
    @(negedge clk);
    #1;
    check("idle_stray_state", w_t'({mem_read, mem_write}), w_t'(0));
    mem_resp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary expected completion");
    $fatal(1);
  end

endmodule
